fetch_pc_reg: RTL and testbench

//   F-stage program counter register for the P7 pipelined MIPS core.

---
 rtl/fetch_pc_reg.sv | 84 ++++++++
 tb/tb_fetch_pc_reg.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_reg.sv
// F-stage program counter with a one-entry pending-redirect buffer for stalled cycles.
// Optional fetch address range check in exc_adel: define FETCH_RANGE_CHECK_EN.
module fetch_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] next_pc,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        exc_adel,
    output logic        redir_pending
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] pend_tgt_reg;
    logic        misaligned;
    logic        out_of_range;

    assign pc            = pc_reg;
    assign pc_plus4      = pc_reg + 32'd4;
    assign redir_pending = (state_reg == HOLD);

    assign misaligned   = (pc_reg[1:0] != 2'b00);
    assign out_of_range = (pc_reg < IM_LO) || (pc_reg > IM_HI);

`ifdef FETCH_RANGE_CHECK_EN
    assign exc_adel = misaligned || out_of_range;
`else
    logic unused_range;
    assign unused_range = out_of_range;
    assign exc_adel     = misaligned;
`endif

    // Exception beats stall; a stalled eret/redirect is parked until the first unstalled edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg       <= RESET_PC;
            state_reg    <= RUN;
            pend_tgt_reg <= 32'd0;
        end else if (exc_req) begin
            pc_reg       <= EXC_PC;
            state_reg    <= RUN;
            pend_tgt_reg <= 32'd0;
        end else if (stall) begin
            if (eret) begin
                pend_tgt_reg <= epc;
                state_reg    <= HOLD;
            end else if (redirect) begin
                pend_tgt_reg <= next_pc;
                state_reg    <= HOLD;
            end
        end else if (eret) begin
            pc_reg       <= epc;
            state_reg    <= RUN;
            pend_tgt_reg <= 32'd0;
        end else if (redirect) begin
            pc_reg       <= next_pc;
            state_reg    <= RUN;
            pend_tgt_reg <= 32'd0;
        end else if (state_reg == HOLD) begin
            pc_reg       <= pend_tgt_reg;
            state_reg    <= RUN;
            pend_tgt_reg <= 32'd0;
        end else begin
            pc_reg <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_fetch_pc_reg.sv
// Directed bench for fetch_pc_reg: reset sequencing, redirects, stalled buffering, eret, exceptions, AdEL.
module tb_fetch_pc_reg;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] next_pc;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        exc_adel;
    logic        redir_pending;

    int checks;
    int errors;

    fetch_pc_reg dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect      (redirect),
        .next_pc       (next_pc),
        .exc_req       (exc_req),
        .eret          (eret),
        .epc           (epc),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .exc_adel      (exc_adel),
        .redir_pending (redir_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then sample on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        $display("txn t=%0t stall=%0b redir=%0b npc=%h eret=%0b epc=%h exc=%0b -> pc=%h pc4=%h adel=%0b pend=%0b",
                 $time, stall, redirect, next_pc, eret, epc, exc_req, pc, pc_plus4, exc_adel, redir_pending);
    endtask

    task automatic idle_inputs();
        stall    = 1'b0;
        redirect = 1'b0;
        next_pc  = 32'd0;
        exc_req  = 1'b0;
        eret     = 1'b0;
        epc      = 32'd0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'h0000_3004;
        exp_seq[1] = 32'h0000_3008;
        exp_seq[2] = 32'h0000_300c;
        idle_inputs();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (pc !== 32'h0000_3000) begin
            errors++;
            $display("FAIL reset_pc got %h exp %h", pc, 32'h0000_3000);
        end
        checks++;
        if (redir_pending !== 1'b0 || exc_adel !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got pend=%0b adel=%0b exp 0 0", redir_pending, exc_adel);
        end
        checks++;
        if (pc_plus4 !== 32'h0000_3004) begin
            errors++;
            $display("FAIL reset_pc_plus4 got %h exp %h", pc_plus4, 32'h0000_3004);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc !== exp_seq[i] || exc_adel !== 1'b0) begin
                errors++;
                $display("FAIL seq_fetch_%0d got pc=%h adel=%0b exp pc=%h adel=0", i, pc, exc_adel, exp_seq[i]);
            end
        end
        tick();
    endtask

    task automatic test_redirect();
        checks++;
        if (pc !== 32'h0000_3010) begin
            errors++;
            $display("FAIL pre_redirect_pc got %h exp %h", pc, 32'h0000_3010);
        end
        redirect = 1'b1;
        next_pc  = 32'h0000_3040;
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h0000_3040 || redir_pending !== 1'b0) begin
            errors++;
            $display("FAIL redirect got pc=%h pend=%0b exp pc=%h pend=0", pc, redir_pending, 32'h0000_3040);
        end
    endtask

    task automatic test_stall_redirect();
        stall    = 1'b1;
        redirect = 1'b1;
        next_pc  = 32'h0000_3080;
        tick();
        redirect = 1'b0;
        next_pc  = 32'h0;
        checks++;
        if (pc !== 32'h0000_3040 || redir_pending !== 1'b1) begin
            errors++;
            $display("FAIL stall_edge1 got pc=%h pend=%0b exp pc=%h pend=1", pc, redir_pending, 32'h0000_3040);
        end
        tick();
        checks++;
        if (pc !== 32'h0000_3040 || redir_pending !== 1'b1) begin
            errors++;
            $display("FAIL stall_edge2 got pc=%h pend=%0b exp pc=%h pend=1", pc, redir_pending, 32'h0000_3040);
        end
        stall = 1'b0;
        tick();
        checks++;
        if (pc !== 32'h0000_3080 || redir_pending !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got pc=%h pend=%0b exp pc=%h pend=0", pc, redir_pending, 32'h0000_3080);
        end
        tick();
        checks++;
        if (pc !== 32'h0000_3084) begin
            errors++;
            $display("FAIL after_release got %h exp %h", pc, 32'h0000_3084);
        end
    endtask

    task automatic test_eret_overwrite();
        stall    = 1'b1;
        redirect = 1'b1;
        next_pc  = 32'h0000_3080;
        tick();
        redirect = 1'b0;
        eret     = 1'b1;
        epc      = 32'h0000_3100;
        tick();
        eret  = 1'b0;
        epc   = 32'h0;
        checks++;
        if (pc !== 32'h0000_3084 || redir_pending !== 1'b1) begin
            errors++;
            $display("FAIL eret_stalled got pc=%h pend=%0b exp pc=%h pend=1", pc, redir_pending, 32'h0000_3084);
        end
        stall = 1'b0;
        tick();
        checks++;
        if (pc !== 32'h0000_3100 || redir_pending !== 1'b0) begin
            errors++;
            $display("FAIL eret_overwrite got pc=%h pend=%0b exp pc=%h pend=0", pc, redir_pending, 32'h0000_3100);
        end
    endtask

    task automatic test_exception();
        stall    = 1'b1;
        redirect = 1'b1;
        next_pc  = 32'h0000_3080;
        tick();
        redirect = 1'b0;
        exc_req  = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h0000_4180 || redir_pending !== 1'b0 || exc_adel !== 1'b0) begin
            errors++;
            $display("FAIL exc_over_stall got pc=%h pend=%0b adel=%0b exp pc=%h pend=0 adel=0",
                     pc, redir_pending, exc_adel, 32'h0000_4180);
        end
        tick();
        checks++;
        if (pc !== 32'h0000_4184) begin
            errors++;
            $display("FAIL exc_pending_dropped got %h exp %h", pc, 32'h0000_4184);
        end
    endtask

    task automatic test_adel();
        logic exp_range;
`ifdef FETCH_RANGE_CHECK_EN
        exp_range = 1'b1;
`else
        exp_range = 1'b0;
`endif
        redirect = 1'b1;
        next_pc  = 32'h0000_3002;
        tick();
        checks++;
        if (pc !== 32'h0000_3002 || exc_adel !== 1'b1 || pc_plus4 !== 32'h0000_3006) begin
            errors++;
            $display("FAIL adel_misaligned got pc=%h adel=%0b pc4=%h exp pc=%h adel=1 pc4=%h",
                     pc, exc_adel, pc_plus4, 32'h0000_3002, 32'h0000_3006);
        end
        next_pc = 32'h0000_7000;
        tick();
        checks++;
        if (pc !== 32'h0000_7000 || exc_adel !== exp_range) begin
            errors++;
            $display("FAIL adel_range got pc=%h adel=%0b exp pc=%h adel=%0b", pc, exc_adel, 32'h0000_7000, exp_range);
        end
        next_pc = 32'h0000_6ffc;
        tick();
        checks++;
        if (exc_adel !== 1'b0) begin
            errors++;
            $display("FAIL adel_im_hi got adel=%0b exp 0", exc_adel);
        end
        next_pc = 32'hffff_fffc;
        tick();
        redirect = 1'b0;
        next_pc  = 32'h0;
        checks++;
        if (pc_plus4 !== 32'h0000_0000 || exc_adel !== exp_range) begin
            errors++;
            $display("FAIL wrap_plus4 got pc4=%h adel=%0b exp pc4=00000000 adel=%0b", pc_plus4, exc_adel, exp_range);
        end
        tick();
        checks++;
        if (pc !== 32'h0000_0000 || exc_adel !== exp_range) begin
            errors++;
            $display("FAIL wrap_pc got pc=%h adel=%0b exp pc=00000000 adel=%0b", pc, exc_adel, exp_range);
        end
    endtask

    task automatic test_async_reset();
        stall    = 1'b1;
        redirect = 1'b1;
        next_pc  = 32'h0000_3500;
        tick();
        idle_inputs();
        stall = 1'b1;
        checks++;
        if (redir_pending !== 1'b1) begin
            errors++;
            $display("FAIL hold_before_reset got pend=%0b exp 1", redir_pending);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h0000_3000 || redir_pending !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got pc=%h pend=%0b exp pc=%h pend=0", pc, redir_pending, 32'h0000_3000);
        end
        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0;
        tick();
        checks++;
        if (pc !== 32'h0000_3004) begin
            errors++;
            $display("FAIL reset_drops_pending got %h exp %h", pc, 32'h0000_3004);
        end
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1;
        next_pc  = 32'h0000_3200;
        tick();
        next_pc = 32'h0000_3300;
        tick();
        checks++;
        if (pc !== 32'h0000_3300) begin
            errors++;
            $display("FAIL b2b_redirect got %h exp %h", pc, 32'h0000_3300);
        end
        next_pc = 32'h0000_3400;
        eret    = 1'b1;
        epc     = 32'h0000_3600;
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h0000_3600) begin
            errors++;
            $display("FAIL eret_beats_redirect got %h exp %h", pc, 32'h0000_3600);
        end
        stall    = 1'b1;
        redirect = 1'b1;
        next_pc  = 32'h0000_3700;
        tick();
        stall   = 1'b0;
        next_pc = 32'h0000_3800;
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h0000_3800 || redir_pending !== 1'b0) begin
            errors++;
            $display("FAIL new_redirect_over_hold got pc=%h pend=%0b exp pc=%h pend=0", pc, redir_pending, 32'h0000_3800);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_redirect();
        test_stall_redirect();
        test_eret_overwrite();
        test_exception();
        test_adel();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
